// File: rtl/banco_pkg.sv
// Shared definitions for the write queue that sits in front of register bank banco.
package banco_pkg;

  localparam int M_DEF = 8;  // data width
  localparam int N_DEF = 4;  // address width
  localparam int D_DEF = 4;  // queue depth

  // One queued write request
  typedef struct packed {
    logic [N_DEF-1:0] addr;
    logic [M_DEF-1:0] data;
  } wr_entry_t;

  // Port-1 arbiter state; ISSUE means a queued write is on the bank port this cycle
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/coda_scritture_if.sv
// Producer/reader side of the write queue.
//
// Handshakes: a push is taken on a rising edge where push=1 and full=0; a
// refused push is reported by push_err one cycle later. A read is taken on a
// rising edge where rd_req=1 and rd_gnt=1; while rd_gnt=0 the requester holds
// rd_req and rd_addr stable. rd_valid/rd_data follow a grant by exactly one cycle.
interface coda_scritture_if
  import banco_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int N = N_DEF
);
  logic         push;
  logic [N-1:0] push_addr;
  logic [M-1:0] push_data;
  logic         full;
  logic         push_err;
  logic         rd_req;
  logic [N-1:0] rd_addr;
  logic         rd_gnt;
  logic         rd_valid;
  logic [M-1:0] rd_data;

  modport master (
    output push, push_addr, push_data, rd_req, rd_addr,
    input  full, push_err, rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  push, push_addr, push_data, rd_req, rd_addr,
    output full, push_err, rd_gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/fifo_scritture.sv
// Circular write buffer. Exposes every slot in age order (index 0 = head)
// with a valid bit so the top level can search pending writes.
module fifo_scritture
  import banco_pkg::*;
#(
  parameter int W  = M_DEF + N_DEF,
  parameter int D  = D_DEF,
  parameter int LD = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [W-1:0]        push_entry,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [D-1:0][W-1:0] entries,
  output logic [D-1:0]        entry_valid
);

  logic [W-1:0]  mem [D];
  logic [LD-1:0] rd_ptr;
  logic [LD-1:0] wr_ptr;
  logic [LD:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == (LD+1)'(D));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo D
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LD'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + LD'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (LD+1)'(1);
        2'b01:   cnt <= cnt - (LD+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: slots are only read when counted as valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // Age-ordered view of the buffer for the forwarding search
  always_comb begin
    entries     = '0;
    entry_valid = '0;
    for (int i = 0; i < D; i++) begin
      entries[i]     = mem[rd_ptr + LD'(i)];
      entry_valid[i] = ((LD+1)'(i) < cnt);
    end
  end

endmodule

// File: rtl/coda_scritture.sv
// Write queue and port-1 arbiter in front of register bank banco.
// Reads win the port unless the queue is full; reads of addresses still
// pending in the queue or on the port are answered with the newest data.
module coda_scritture
  import banco_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int N  = N_DEF,
  parameter int D  = D_DEF,
  parameter int LD = 2
) (
  input  logic                clk,
  input  logic                reset,
  coda_scritture_if.slave     bus,
  output logic                b_wrt,
  output logic [N-1:0]        b_addr1,
  output logic [M-1:0]        b_min,
  input  logic [M-1:0]        b_mout1
);

  localparam int W = N + M;

  arb_state_t          state;
  logic                full;
  logic                empty;
  logic [D-1:0][W-1:0] entries;
  logic [D-1:0]        entry_valid;
  logic                gnt;
  logic                pop;
  logic                fwd_hit;
  logic [M-1:0]        fwd_data;
  logic                hit_q;
  logic [M-1:0]        fwd_q;
  logic                rd_valid_q;
  logic                push_err_q;

  fifo_scritture #(.W(W), .D(D), .LD(LD)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.push),
    .push_entry ({bus.push_addr, bus.push_data}),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .entries    (entries),
    .entry_valid(entry_valid)
  );

  // A full queue blocks reads so the drain can make room
  assign gnt = bus.rd_req && !full;
  assign pop = !gnt && !empty;

  assign bus.rd_gnt   = gnt;
  assign bus.full     = full;
  assign bus.push_err = push_err_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? (hit_q ? fwd_q : b_mout1) : '0;

  // The bank must never be written on a reset edge, even with a write in flight
  assign b_wrt = (state == ARB_ISSUE) && !reset;

  // Forwarding search: in-flight write is oldest, queue scanned head to tail so the newest match wins
  always_comb begin
    fwd_hit  = (state == ARB_ISSUE) && (b_addr1 == bus.rd_addr);
    fwd_data = b_min;
    for (int i = 0; i < D; i++) begin
      if (entry_valid[i] && (entries[i][W-1:M] == bus.rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[i][M-1:0];
      end
    end
  end

  // Port-1 arbiter: read address, queued write, or idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      b_addr1 <= '0;
      b_min   <= '0;
    end else if (gnt) begin
      state   <= ARB_IDLE;
      b_addr1 <= bus.rd_addr;
    end else if (!empty) begin
      state   <= ARB_ISSUE;
      b_addr1 <= entries[0][W-1:M];
      b_min   <= entries[0][M-1:0];
    end else begin
      state   <= ARB_IDLE;
    end
  end

  // Read return and push-refusal flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      fwd_q      <= '0;
      push_err_q <= 1'b0;
    end else begin
      rd_valid_q <= gnt;
      hit_q      <= fwd_hit;
      fwd_q      <= fwd_data;
      push_err_q <= bus.push && full;
    end
  end

endmodule

// File: tb/tb_coda_scritture.sv
// Bench for coda_scritture: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-level model.
module tb_coda_scritture;
  import banco_pkg::*;

  localparam int M = 8;
  localparam int N = 4;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coda_scritture_if #(.M(M), .N(N)) bus ();
  logic         b_wrt;
  logic [N-1:0] b_addr1;
  logic [M-1:0] b_min;
  logic [M-1:0] b_mout1;

  coda_scritture #(.M(M), .N(N), .D(D), .LD(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .b_wrt  (b_wrt),
    .b_addr1(b_addr1),
    .b_min  (b_min),
    .b_mout1(b_mout1)
  );

  // Register bank banco: combinational read, write on rising edge
  logic [M-1:0] bank [16] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2,
                              8'hAD, 8'hAC, 8'hAF, 8'hAE, 8'hA9, 8'hA8, 8'hAB, 8'hAA};
  assign b_mout1 = bank[b_addr1];
  always @(posedge clk) if (b_wrt) bank[b_addr1] <= b_min;

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending writes as a queue, one write on the port, bank image
  bit           model_on = 1'b0;
  wr_entry_t    mq[$];
  bit           m_inf_v;
  logic [N-1:0] m_addr1;
  logic [M-1:0] m_min;
  logic [M-1:0] m_mem [16];
  bit           m_perr;
  logic [M-1:0] exp_q[$];
  bit           full_m, gnt_m, hit_m;
  logic [M-1:0] val_m;
  wr_entry_t    e_m;

  // Compare outputs against the model, then advance the model across the next edge
  always @(negedge clk) begin
    if (model_on) begin
      full_m = (mq.size() == D);
      chk("b_wrt", 32'(b_wrt), 32'(m_inf_v && !reset));
      chk("b_addr1", 32'(b_addr1), 32'(m_addr1));
      chk("b_min", 32'(b_min), 32'(m_min));
      chk("full", 32'(bus.full), 32'(full_m));
      chk("push_err", 32'(bus.push_err), 32'(m_perr));
      chk("rd_gnt", 32'(bus.rd_gnt), 32'(bus.rd_req && !full_m));
      chk("rd_valid", 32'(bus.rd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      if (reset) begin
        mq.delete();
        exp_q.delete();
        m_inf_v = 1'b0;
        m_addr1 = '0;
        m_min   = '0;
        m_perr  = 1'b0;
      end else begin
        gnt_m = bus.rd_req && !full_m;
        hit_m = 1'b0;
        val_m = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (!hit_m && mq[i].addr == bus.rd_addr) begin
            hit_m = 1'b1;
            val_m = mq[i].data;
          end
        end
        if (!hit_m && m_inf_v && m_addr1 == bus.rd_addr) begin
          hit_m = 1'b1;
          val_m = m_min;
        end
        if (m_inf_v) m_mem[m_addr1] = m_min;
        if (gnt_m) exp_q.push_back(hit_m ? val_m : m_mem[bus.rd_addr]);
        m_perr = bus.push && full_m;
        if (gnt_m) begin
          m_inf_v = 1'b0;
          m_addr1 = bus.rd_addr;
        end else if (mq.size() != 0) begin
          e_m     = mq.pop_front();
          m_inf_v = 1'b1;
          m_addr1 = e_m.addr;
          m_min   = e_m.data;
        end else begin
          m_inf_v = 1'b0;
        end
        if (bus.push && !full_m) mq.push_back('{addr: bus.push_addr, data: bus.push_data});
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit last_gnt;

  task automatic cyc();
    @(negedge clk);
    last_gnt = bus.rd_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.push      = 1'b0;
    bus.push_addr = '0;
    bus.push_data = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
  endtask

  task automatic do_push(input logic [N-1:0] a, input logic [M-1:0] d);
    bus.push      = 1'b1;
    bus.push_addr = a;
    bus.push_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'hA5 ^ 8'(i);
    m_inf_v = 1'b0; m_addr1 = '0; m_min = '0; m_perr = 1'b0;
    reset = 1'b1;
    idle_inputs();

    // Reset held two cycles, then idle
    @(posedge clk); #1;
    model_on = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_b_wrt", 32'(b_wrt), 0);
      chk("idle_b_addr1", 32'(b_addr1), 0);
      chk("idle_full", 32'(bus.full), 0);
      chk("idle_rd_valid", 32'(bus.rd_valid), 0);
      chk("idle_rd_data", 32'(bus.rd_data), 0);
      cyc();
    end

    // Single write, then read it back from the bank
    do_push(4'd7, 8'd127);
    cyc();
    bus.push = 1'b0;
    cyc();
    chk("single_b_wrt", 32'(b_wrt), 1);
    chk("single_b_addr1", 32'(b_addr1), 7);
    chk("single_b_min", 32'(b_min), 127);
    cyc();
    chk("single_bank7", 32'(bank[7]), 127);
    bus.rd_req = 1'b1; bus.rd_addr = 4'd7;
    cyc();
    bus.rd_req = 1'b0;
    chk("single_rd_valid", 32'(bus.rd_valid), 1);
    chk("single_rd_data", 32'(bus.rd_data), 127);
    cyc();

    // Fill with reads holding off the drain, overflow, then drain in order
    for (int i = 1; i <= 4; i++) begin
      do_push(4'(i), 8'(i * 10));
      bus.rd_req = 1'b1; bus.rd_addr = 4'd15;
      cyc();
    end
    chk("fill_full", 32'(bus.full), 1);
    do_push(4'd5, 8'd50);
    cyc();
    chk("ovf_push_err", 32'(bus.push_err), 1);
    chk("ovf_full", 32'(bus.full), 0);
    chk("drain1_b_wrt", 32'(b_wrt), 1);
    chk("drain1_b_addr1", 32'(b_addr1), 1);
    chk("drain1_b_min", 32'(b_min), 10);
    idle_inputs();
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk("drain_b_wrt", 32'(b_wrt), 1);
      chk("drain_b_addr1", 32'(b_addr1), 32'(i));
      chk("drain_b_min", 32'(b_min), 32'(i * 10));
    end
    cyc();
    chk("ovf_not_stored", 32'(b_wrt), 0);
    cyc();

    // Forwarding of the newest of two writes to the same address
    do_push(4'd8, 8'd255);
    cyc();
    do_push(4'd8, 8'd17);
    cyc();
    bus.push = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 4'd8;
    cyc();
    bus.rd_req = 1'b0;
    chk("fwd_rd_valid", 32'(bus.rd_valid), 1);
    chk("fwd_rd_data", 32'(bus.rd_data), 17);
    for (int i = 0; i < 3; i++) cyc();

    // Full-queue read stall
    for (int i = 0; i < 4; i++) begin
      do_push(4'(10 + i), 8'($urandom_range(0, 255)));
      bus.rd_req = 1'b1; bus.rd_addr = 4'd9;
      cyc();
    end
    bus.push = 1'b0;
    bus.rd_addr = 4'd0;
    #1;
    chk("stall_full", 32'(bus.full), 1);
    chk("stall_rd_gnt", 32'(bus.rd_gnt), 0);
    cyc();
    chk("stall_release_gnt", 32'(bus.rd_gnt), 1);
    cyc();
    bus.rd_req = 1'b0;
    chk("stall_rd_valid", 32'(bus.rd_valid), 1);
    chk("stall_rd_data", 32'(bus.rd_data), 32'h00A5);
    for (int i = 0; i < 5; i++) cyc();

    // Reset mid-drain discards queued and in-flight writes
    for (int i = 0; i < 3; i++) begin
      do_push(4'(1 + i), 8'(8'hC0 + i));
      bus.rd_req = 1'b1; bus.rd_addr = 4'd9;
      cyc();
    end
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_b_wrt", 32'(b_wrt), 0);
    chk("rst_b_addr1", 32'(b_addr1), 0);
    chk("rst_bank1", 32'(bank[1]), 10);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rst_no_write", 32'(b_wrt), 0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) != 0) begin
        do_push(($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)));
      end else begin
        bus.push = 1'b0;
      end
      if (!(bus.rd_req && !last_gnt)) begin
        bus.rd_req  = ($urandom_range(0, 2) == 0);
        bus.rd_addr = 4'($urandom_range(0, 3));
      end
      cyc();
    end
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 10; i++) cyc();

    // Final bank image must match the model's write history
    for (int i = 0; i < 16; i++) chk("bank_final", 32'(bank[i]), 32'(m_mem[i]));

    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/coda_scritture.md
Name: coda_scritture

Overview:
- Write queue and port-1 arbiter placed directly upstream of the register bank `banco`.
- Buffers (address, data) write requests from the producer and drains them into the bank one per cycle.
- Owns the bank's shared port 1: drives wrt/addr1/Min and interleaves port-1 reads with queued writes.
- Forwards the newest pending data when a read hits an address still queued or in flight.

Parameters:
M, 8, data width (matches banco M)
N, 4, address width (matches banco N)
D, 4, queue depth in entries, power of two, >=2
LD, 2, log2(D), pointer width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset, sampled on rising edge of clk
push  in  1  producer write request
push_addr  in  N  target register of the write
push_data  in  M  data to write
full  out  1  queue holds D entries; a push this cycle is refused
push_err  out  1  one-cycle pulse: previous-cycle push was refused
rd_req  in  1  port-1 read request
rd_addr  in  N  port-1 read address
rd_gnt  out  1  read accepted this cycle (combinational)
rd_valid  out  1  rd_data valid; one cycle after rd_gnt
rd_data  out  M  read result (bank Mout1 or forwarded value)
b_wrt  out  1  to banco wrt
b_addr1  out  N  to banco addr1
b_min  out  M  to banco Min
b_mout1  in  M  from banco Mout1

Behaviour:
- Reset values: b_wrt=0, b_addr1=0, b_min=0, rd_valid=0, rd_data=0, push_err=0, pointers=0, count=0. Consequently full=0.
- Reset mid-operation discards all queued and in-flight writes; the bank is not written during the reset cycle.
- Queue: circular FIFO with rd_ptr, wr_ptr (LD bits, wrap modulo D) and count (LD+1 bits).
- full = (count==D); empty = (count==0).
- Push accepted when push=1 and full=0. A push while full is dropped, and push_err=1 on the next cycle.
- Push and pop in the same cycle are both allowed when 0<count<D; count is unchanged.
- A push into an empty queue cannot drain in the same cycle (no write-through).

Arbiter, evaluated each cycle on registered queue state. Two states, IDLE and ISSUE, with b_wrt being the ISSUE flag:
- rd_req=1 and full=0: grant the read.
  - rd_gnt=1, no pop.
  - Next edge: b_wrt<=0, b_addr1<=rd_addr.
- Otherwise, if empty=0: pop the head.
  - Next edge: b_wrt<=1, b_addr1<=head.addr, b_min<=head.data.
- Otherwise: b_wrt<=0; b_addr1 and b_min hold.
- full=1 gives writes priority: rd_req is stalled with rd_gnt=0, and the requester holds rd_req/rd_addr.

Write latency:
- Push accepted at edge k → earliest b_wrt=1 after edge k+1 → bank written at edge k+2.
- Write order equals push order; the bank only ever sees writes in FIFO order.

Read timing:
- rd_gnt at cycle c → rd_valid=1 after edge c+1.
- rd_data is registered at edge c+1.

Forwarding, evaluated at grant time and registered with rd_valid:
- Search order: (1) queue entries newest→oldest, (2) the in-flight ISSUE register (b_wrt=1).
- First address match supplies the data.
- No match → rd_data is taken from b_mout1 in the cycle after grant, i.e. b_addr1 = rd_addr with b_wrt=0.
- Implementation: rd_data is muxed at the rd_valid edge using a registered hit flag and registered forward data.
- A read of an address pushed in the same cycle does not see that push.

Decomposition:
- Shared package `banco_pkg`:
  - constants M_DEF=8, N_DEF=4, D_DEF=4;
  - typedef `wr_entry_t` = {addr[N], data[M]}.
- One sub-module, `fifo_scritture`: circular buffer with pointers/count/full/empty and a flat read-out of all D entries with valid bits for the forwarding search.
- Arbiter and forwarding logic stay in the top level.

Test Plan:
1. Reset then idle: hold reset 2 cycles, no requests → b_wrt=0, b_addr1=0, full=0, rd_valid=0 throughout.
2. Single write: push addr=7 data=127 at edge k → b_wrt=1, b_addr1=7, b_min=127 after edge k+1. A later rd_req addr=7 with the queue empty → rd_valid with rd_data=127 from the bank.
3. Fill and overflow: 4 back-to-back pushes (addr 1..4, data 10..40) while rd_req=1 holds drains off:
   - full=1 after the 4th;
   - a 5th push → push_err=1 next cycle, entry not stored;
   - drop rd_req → bank writes occur in order 1,2,3,4.
4. Forwarding: push addr=8 data=255, then addr=8 data=17; immediately rd_req addr=8 → rd_data=17, never 255 and never the stale bank value.
5. Full-queue read stall: queue full, rd_req addr=0 → rd_gnt=0 until count<4. Then grant, rd_valid next cycle with the bank value for addr 0.
6. Reset mid-drain: 3 entries queued, assert reset for one cycle → count=0, b_wrt=0, and no further bank writes occur.
